uart_rx_ctrl: RTL and testbench

Parametrised UART receiver for the microcontroller peripheral set. Receives frames of 5 to DATA_MAX data bits, with optional odd/even parity, 1 or 2 stop bits and selectable bit order. It detects parity, framing and break errors, and buffers each received word with its error flags in a small FIFO behind a valid/ready handshake. It replaces the fixed 8-bit receive path for new designs.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_if.sv | 18 +
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, receiver FSM states and receive error flags.
package uart_pkg;

  typedef enum logic [1:0] {
    NO_PARITY   = 2'd0,
    ODD_PARITY  = 2'd1,
    EVEN_PARITY = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } rx_state_t;

  typedef struct packed {
    logic brk;
    logic framing;
    logic parity;
  } rx_err_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-word handshake: the receiver presents the FIFO head, the consumer accepts it.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_MAX-1:0] rx_data;
  uart_pkg::rx_err_t   rx_err;
  logic                rx_valid;
  logic                rx_ready;
  logic [LevelW-1:0]   rx_level;

  modport master (output rx_data, output rx_err, output rx_valid, output rx_level,
                  input rx_ready);
  modport slave  (input rx_data, input rx_err, input rx_valid, input rx_level,
                  output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full succeeds only alongside a pop.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AddrW  = $clog2(DEPTH),
  localparam int unsigned LevelW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [LevelW-1:0] level
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LevelW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count_q;
  // Head word reads as zero when empty so the output is clean after reset.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LevelW'(1);
        2'b01:   count_q <= count_q - LevelW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Configurable UART receiver: synchroniser, bit-period counter, frame FSM and receive FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX     = 9,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    rx_in,
  input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
  input  logic [3:0]              data_width,
  input  logic [1:0]              stop_bits,
  input  parity_t                 parity,
  input  logic                    lsb_first,
  uart_rx_ctrl_if.master          rx_bus,
  output logic                    overrun,
  output logic                    busy,
  output rx_state_t               state_o
);

  localparam int unsigned FifoW  = DATA_MAX + 3;
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]              sync_q;
  logic                    s, s_d_q;
  rx_state_t               state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] cnt_q, cnt_d, spb_q, spb_d;
  logic [4:0]              bit_q, bit_d, width_q, width_d, width_in;
  logic [DATA_MAX-1:0]     data_q, data_d;
  logic                    par_q, par_d, framing_q, framing_d;
  logic                    two_stop_q, two_stop_d, lsb_q, lsb_d;
  parity_t                 par_cfg_q, par_cfg_d;
  logic                    sample, push, pop, overrun_q;
  rx_err_t                 err_fin;
  logic [FifoW-1:0]        fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [LevelW-1:0]       fifo_level;

  assign s = sync_q[1];
  assign width_in = ({1'b0, data_width} < 5'd5)           ? 5'd5 :
                    ({1'b0, data_width} > 5'(DATA_MAX))   ? 5'(DATA_MAX) :
                    {1'b0, data_width};

  // Next-state, sampling and frame-completion logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    par_d      = par_q;
    framing_d  = framing_q;
    width_d    = width_q;
    two_stop_d = two_stop_q;
    par_cfg_d  = par_cfg_q;
    lsb_d      = lsb_q;
    spb_d      = spb_q;
    push       = 1'b0;
    sample     = (cnt_q == '0);

    err_fin.framing = framing_q | ~s;
    err_fin.brk     = err_fin.framing && (data_q == '0) && !par_q;
    unique case (par_cfg_q)
      EVEN_PARITY: err_fin.parity = (^data_q) ^ par_q;
      ODD_PARITY:  err_fin.parity = ~((^data_q) ^ par_q);
      default:     err_fin.parity = 1'b0;
    endcase

    if (state_q inside {StStart, StData, StParity, StStop}) begin
      cnt_d = sample ? spb_q - SAMPLE_WIDTH'(1) : cnt_q - SAMPLE_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (enable && s_d_q && !s) begin
          width_d    = width_in;
          two_stop_d = (stop_bits >= 2'd2);
          par_cfg_d  = parity;
          lsb_d      = lsb_first;
          spb_d      = samples_per_bit;
          cnt_d      = samples_per_bit >> 1;
          bit_d      = '0;
          data_d     = '0;
          par_d      = 1'b0;
          framing_d  = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (sample) state_d = s ? StIdle : StData;
      end
      StData: begin
        if (sample) begin
          if (lsb_q) begin
            for (int unsigned i = 0; i < DATA_MAX; i++) begin
              if (5'(i) == bit_q) data_d[i] = s;
            end
          end else begin
            data_d = {data_q[DATA_MAX-2:0], s};
          end
          bit_d = bit_q + 5'd1;
          if (bit_q == width_q - 5'd1) begin
            bit_d   = '0;
            state_d = (par_cfg_q != NO_PARITY) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (sample) begin
          par_d   = s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          framing_d = err_fin.framing;
          if (two_stop_q && (bit_q == '0)) begin
            bit_d = 5'd1;
          end else begin
            push    = 1'b1;
            state_d = err_fin.framing ? StWaitIdle : StIdle;
          end
        end
      end
      StWaitIdle: begin
        // Hold here while a break persists so it cannot look like a new start bit.
        if (s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && !enable) begin
      state_d = StIdle;
      push    = 1'b0;
    end
  end

  // Synchroniser, edge history and FSM/datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      s_d_q      <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      framing_q  <= 1'b0;
      width_q    <= 5'd5;
      two_stop_q <= 1'b0;
      par_cfg_q  <= NO_PARITY;
      lsb_q      <= 1'b1;
      spb_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_in};
      s_d_q      <= s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_q      <= par_d;
      framing_q  <= framing_d;
      width_q    <= width_d;
      two_stop_q <= two_stop_d;
      par_cfg_q  <= par_cfg_d;
      lsb_q      <= lsb_d;
      spb_q      <= spb_d;
      overrun_q  <= push && fifo_full && !pop;
    end
  end

  assign pop = rx_bus.rx_valid && rx_bus.rx_ready;

  uart_rx_fifo #(
    .WIDTH (FifoW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({err_fin, data_q}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign rx_bus.rx_data  = fifo_rdata[DATA_MAX-1:0];
  assign rx_bus.rx_err   = rx_err_t'(fifo_rdata[FifoW-1:DATA_MAX]);
  assign rx_bus.rx_valid = !fifo_empty;
  assign rx_bus.rx_level = fifo_level;
  assign overrun         = overrun_q;
  assign busy            = (state_q != StIdle);
  assign state_o         = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized frames vs a model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DataMax = 9;
  localparam int unsigned SampleW = 16;
  localparam int unsigned Depth   = 4;

  logic              clk = 1'b0;
  logic              reset_n, enable, rx_in, lsb_first, overrun, busy;
  logic [SampleW-1:0] spb;
  logic [3:0]        data_width;
  logic [1:0]        stop_bits;
  parity_t           parity;
  rx_state_t         state_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ovr_total = 0;

  uart_rx_ctrl_if #(.DATA_MAX(DataMax), .FIFO_DEPTH(Depth)) bus ();

  uart_rx_ctrl #(
    .DATA_MAX     (DataMax),
    .SAMPLE_WIDTH (SampleW),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .rx_in           (rx_in),
    .samples_per_bit (spb),
    .data_width      (data_width),
    .stop_bits       (stop_bits),
    .parity          (parity),
    .lsb_first       (lsb_first),
    .rx_bus          (bus),
    .overrun         (overrun),
    .busy            (busy),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ovr_total <= ovr_total + 1;

  // Hold the line at v for a number of clock cycles (drive point is just after posedge).
  task automatic line(input logic v, input int cycles);
    rx_in = v;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int w, input parity_t pm, input int nstop, input logic lsb,
                         input int n);
    data_width = 4'(w);
    parity     = pm;
    stop_bits  = (nstop == 2) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
    lsb_first  = lsb;
    spb        = SampleW'(n);
  endtask

  // Serialise one frame: start, w data bits in the chosen order, optional parity, stops.
  task automatic send_frame(input logic [15:0] d, input int w, input parity_t pm,
                            input logic pbit, input int nstop, input logic stop_val,
                            input logic lsb, input int n);
    logic [15:0] sh;
    line(1'b0, n);
    for (int i = 0; i < w; i++) begin
      sh = lsb ? (d >> i) : (d >> (w - 1 - i));
      line(sh[0], n);
    end
    if (pm != NO_PARITY) line(pbit, n);
    for (int i = 0; i < nstop; i++) line(stop_val, n);
    rx_in = 1'b1;
  endtask

  function automatic int clamp_w(input int w);
    return (w < 5) ? 5 : (w > int'(DataMax)) ? int'(DataMax) : w;
  endfunction

  // Expected {brk, framing, parity, data} for a frame, from the frame-level rules.
  function automatic logic [11:0] model(input logic [15:0] d, input int w, input parity_t pm,
                                        input logic pbit, input logic stop_ok);
    logic [15:0] dm16;
    logic [8:0]  dm;
    int          ones;
    logic        perr, fr, brk;
    dm16 = d & ((16'd1 << w) - 16'd1);
    dm   = dm16[8:0];
    ones = $countones(dm) + ((pm != NO_PARITY && pbit) ? 1 : 0);
    perr = (pm == EVEN_PARITY) ? (ones % 2 == 1) : (pm == ODD_PARITY) ? (ones % 2 == 0) : 1'b0;
    fr   = !stop_ok;
    brk  = fr && (dm == 9'd0) && !(pm != NO_PARITY && pbit);
    return {brk, fr, perr, dm};
  endfunction

  // Sample the head word, then pulse rx_ready for one cycle.
  task automatic pop_word(output logic [8:0] d, output logic [2:0] e, output logic v);
    v = bus.rx_valid;
    d = bus.rx_data;
    e = bus.rx_err;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    rx_in = 1'b1;
    bus.rx_ready = 1'b0;
    set_cfg(8, NO_PARITY, 1, 1'b1, 16);
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rx_valid); else pass_cnt++;
    total_cnt++; if (bus.rx_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.rx_level); else pass_cnt++;
    total_cnt++; if (bus.rx_data !== 9'd0) $display("FAIL reset_data: got %h want 0", bus.rx_data); else pass_cnt++;
    total_cnt++; if (bus.rx_err !== 3'd0) $display("FAIL reset_err: got %b want 000", bus.rx_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (state_o !== StIdle) $display("FAIL reset_state: got %0d want %0d", state_o, StIdle); else pass_cnt++;
    reset_n = 1'b1;
    enable = 1'b1;
    line(1'b1, 4);
  endtask

  task automatic test_8n1_timing();
    logic [8:0] d; logic [2:0] e; logic v;
    set_cfg(8, NO_PARITY, 1, 1'b1, 16);
    fork
      send_frame(16'hA5, 8, NO_PARITY, 1'b0, 1, 1'b1, 1'b1, 16);
      begin
        // Stop sample falls in the cycle after edge 3 + N/2 + 9N; valid shows one cycle later.
        repeat (3 + 8 + 9 * 16) @(posedge clk);
        #1;
        total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL t8n1_valid_early: got %b want 0", bus.rx_valid); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (bus.rx_valid !== 1'b1) $display("FAIL t8n1_valid_rise: got %b want 1", bus.rx_valid); else pass_cnt++;
      end
    join
    line(1'b1, 16);
    pop_word(d, e, v);
    total_cnt++; if (d !== 9'h0A5) $display("FAIL t8n1_data: got %h want 0a5", d); else pass_cnt++;
    total_cnt++; if (e !== 3'b000) $display("FAIL t8n1_err: got %b want 000", e); else pass_cnt++;
  endtask

  task automatic test_parity_7e2();
    logic [8:0] d; logic [2:0] e; logic v;
    set_cfg(7, EVEN_PARITY, 2, 1'b1, 8);
    send_frame(16'h41, 7, EVEN_PARITY, 1'b1, 2, 1'b1, 1'b1, 8);
    line(1'b1, 16);
    pop_word(d, e, v);
    total_cnt++; if (d !== 9'h041) $display("FAIL p7e2_data: got %h want 041", d); else pass_cnt++;
    total_cnt++; if (e !== 3'b001) $display("FAIL p7e2_err: got %b want 001", e); else pass_cnt++;
  endtask

  task automatic test_framing();
    logic [8:0] d; logic [2:0] e; logic v;
    set_cfg(8, NO_PARITY, 1, 1'b1, 16);
    send_frame(16'h3C, 8, NO_PARITY, 1'b0, 1, 1'b0, 1'b1, 16);
    line(1'b0, 32);
    total_cnt++; if (state_o !== StWaitIdle) $display("FAIL frm_wait_state: got %0d want %0d", state_o, StWaitIdle); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL frm_busy: got %b want 1", busy); else pass_cnt++;
    line(1'b1, 6);
    total_cnt++; if (state_o !== StIdle) $display("FAIL frm_idle_state: got %0d want %0d", state_o, StIdle); else pass_cnt++;
    pop_word(d, e, v);
    total_cnt++; if (d !== 9'h03C) $display("FAIL frm_data: got %h want 03c", d); else pass_cnt++;
    total_cnt++; if (e !== 3'b010) $display("FAIL frm_err: got %b want 010", e); else pass_cnt++;
  endtask

  task automatic test_break();
    logic [8:0] d; logic [2:0] e; logic v;
    set_cfg(8, NO_PARITY, 1, 1'b1, 16);
    line(1'b0, 20 * 16);
    total_cnt++; if (bus.rx_level !== 3'd1) $display("FAIL brk_level_low: got %0d want 1", bus.rx_level); else pass_cnt++;
    total_cnt++; if (state_o !== StWaitIdle) $display("FAIL brk_state: got %0d want %0d", state_o, StWaitIdle); else pass_cnt++;
    line(1'b1, 16);
    total_cnt++; if (bus.rx_level !== 3'd1) $display("FAIL brk_level_high: got %0d want 1", bus.rx_level); else pass_cnt++;
    pop_word(d, e, v);
    total_cnt++; if (d !== 9'h000) $display("FAIL brk_data: got %h want 000", d); else pass_cnt++;
    total_cnt++; if (e !== 3'b110) $display("FAIL brk_err: got %b want 110", e); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [8:0] d; logic [2:0] e; logic v;
    int o0;
    set_cfg(8, NO_PARITY, 1, 1'b1, 8);
    o0 = ovr_total;
    for (int i = 1; i <= 5; i++) begin
      send_frame(16'(i), 8, NO_PARITY, 1'b0, 1, 1'b1, 1'b1, 8);
      line(1'b1, 8);
    end
    line(1'b1, 2);
    total_cnt++; if (bus.rx_level !== 3'd4) $display("FAIL ovr_level: got %0d want 4", bus.rx_level); else pass_cnt++;
    total_cnt++; if (ovr_total - o0 != 1) $display("FAIL ovr_pulses: got %0d want 1", ovr_total - o0); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      pop_word(d, e, v);
      total_cnt++; if (d !== 9'(i)) $display("FAIL ovr_pop%0d: got %h want %h", i, d, 9'(i)); else pass_cnt++;
    end
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", bus.rx_valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    set_cfg(8, NO_PARITY, 1, 1'b1, 16);
    line(1'b0, 3);
    line(1'b1, 40);
    total_cnt++; if (state_o !== StIdle) $display("FAIL glitch_state: got %0d want %0d", state_o, StIdle); else pass_cnt++;
    total_cnt++; if (bus.rx_level !== 3'd0) $display("FAIL glitch_level: got %0d want 0", bus.rx_level); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_msb_9o1();
    logic [8:0] d; logic [2:0] e; logic v;
    set_cfg(9, ODD_PARITY, 1, 1'b0, 16);
    send_frame(16'h1F0, 9, ODD_PARITY, 1'b0, 1, 1'b1, 1'b0, 16);
    line(1'b1, 16);
    pop_word(d, e, v);
    total_cnt++; if (d !== 9'h1F0) $display("FAIL msb_data: got %h want 1f0", d); else pass_cnt++;
    total_cnt++; if (e !== 3'b000) $display("FAIL msb_err: got %b want 000", e); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [8:0] d; logic [2:0] e; logic v;
    set_cfg(8, NO_PARITY, 1, 1'b1, 16);
    line(1'b0, 16);
    line(1'b1, 16);
    line(1'b0, 16);
    reset_n = 1'b0;
    line(1'b1, 2);
    total_cnt++; if (state_o !== StIdle) $display("FAIL rmid_state: got %0d want %0d", state_o, StIdle); else pass_cnt++;
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", bus.rx_valid); else pass_cnt++;
    reset_n = 1'b1;
    line(1'b1, 32);
    send_frame(16'h5A, 8, NO_PARITY, 1'b0, 1, 1'b1, 1'b1, 16);
    line(1'b1, 16);
    pop_word(d, e, v);
    total_cnt++; if (v !== 1'b1) $display("FAIL rmid_next_valid: got %b want 1", v); else pass_cnt++;
    total_cnt++; if (d !== 9'h05A) $display("FAIL rmid_next_data: got %h want 05a", d); else pass_cnt++;
    total_cnt++; if (e !== 3'b000) $display("FAIL rmid_next_err: got %b want 000", e); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] d; logic [2:0] e; logic v;
    logic [11:0] expq[$];
    logic [11:0] x;
    logic [15:0] w;
    set_cfg(8, NO_PARITY, 1, 1'b1, 8);
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom_range(0, 255));
      expq.push_back(model(w, 8, NO_PARITY, 1'b0, 1'b1));
      send_frame(w, 8, NO_PARITY, 1'b0, 1, 1'b1, 1'b1, 8);
    end
    line(1'b1, 16);
    total_cnt++; if (bus.rx_level !== 3'd3) $display("FAIL b2b_level: got %0d want 3", bus.rx_level); else pass_cnt++;
    while (expq.size() > 0) begin
      x = expq.pop_front();
      pop_word(d, e, v);
      total_cnt++; if (d !== x[8:0]) $display("FAIL b2b_data: got %h want %h", d, x[8:0]); else pass_cnt++;
      total_cnt++; if (e !== x[11:9]) $display("FAIL b2b_err: got %b want %b", e, x[11:9]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [8:0] d; logic [2:0] e; logic v;
    logic [11:0] x;
    logic [15:0] w;
    int cw, we, nstop, n;
    parity_t pm;
    logic lsb, pbit, stop_ok;
    for (int it = 0; it < 20; it++) begin
      cw      = $urandom_range(3, 15);
      we      = clamp_w(cw);
      pm      = parity_t'(2'($urandom_range(0, 2)));
      nstop   = $urandom_range(1, 2);
      lsb     = 1'($urandom_range(0, 1));
      n       = $urandom_range(4, 12);
      w       = 16'($urandom);
      pbit    = 1'($urandom_range(0, 1));
      stop_ok = ($urandom_range(0, 4) != 0);
      if (it == 0) w = 16'h0;
      set_cfg(cw, pm, nstop, lsb, n);
      x = model(w, we, pm, pbit, stop_ok);
      send_frame(w, we, pm, pbit, nstop, stop_ok, lsb, n);
      line(1'b1, 2 * n + 4);
      pop_word(d, e, v);
      total_cnt++; if (v !== 1'b1) $display("FAIL rnd%0d_valid: got %b want 1", it, v); else pass_cnt++;
      total_cnt++; if (d !== x[8:0]) $display("FAIL rnd%0d_data: got %h want %h", it, d, x[8:0]); else pass_cnt++;
      total_cnt++; if (e !== x[11:9]) $display("FAIL rnd%0d_err: got %b want %b", it, e, x[11:9]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_8n1_timing();
    test_parity_7e2();
    test_framing();
    test_break();
    test_overrun();
    test_glitch();
    test_msb_9o1();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
